unidade_busca_pc: RTL and testbench

Program-counter register and fetch sequencer for the MIPS core. Holds the current PC and drives it to the PC+4 adder. Consumes the adder result and the branch/jump/jr targets, selects the next PC, and runs a request/ready handshake with instruction memory. Delivers each fetched instruction with its PC to the decode stage.

---
 rtl/unidade_busca_pc.sv | 139 +++++++++++++
 tb/tb_unidade_busca_pc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca_pc.sv
// Program-counter register and fetch sequencer: selects the next PC, handshakes with
// instruction memory and hands each fetched word plus its PC to decode.
module unidade_busca_pc #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] pc_mais4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] contador_instr,
    output logic        erro_alinhamento
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        BUSCA = 1'b0,
        ERRO  = 1'b1
    } estado_t;

    estado_t          state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]  contador_q, contador_d;
    logic             erro_q, erro_d;
    logic             pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]  pend_target_q, pend_target_d;

    logic             imem_req_c;
    logic             aceite_c;
    logic             redir_c;
    logic [XLEN-1:0]  redir_target_c;
    logic [XLEN-1:0]  next_pc_c;

    // Next-state and output logic; same-cycle redirects take priority over the pending one
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_valid_d  = 1'b0;
        contador_d     = contador_q;
        erro_d         = erro_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        redir_c        = 1'b1;
        redir_target_c = pc_mais4;

        imem_req_c = (state_q == BUSCA) && !stall && !reset;
        aceite_c   = imem_req_c && imem_ready;

        if (jr) begin
            redir_target_c = jr_target;
        end else if (jump) begin
            redir_target_c = jump_target;
        end else if (branch_taken) begin
            redir_target_c = branch_target;
        end else begin
            redir_c = 1'b0;
        end

        if (redir_c) begin
            next_pc_c = redir_target_c;
        end else if (pend_valid_q) begin
            next_pc_c = pend_target_q;
        end else begin
            next_pc_c = pc_mais4;
        end

        if (state_q == BUSCA) begin
            if (aceite_c) begin
                instr_d       = imem_data;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                contador_d    = contador_q + XLEN'(1);
                pend_valid_d  = 1'b0;
                // A misaligned target still delivers the word but halts fetch
                if (next_pc_c[1:0] != 2'b00) begin
                    state_d = ERRO;
                    erro_d  = 1'b1;
                end else begin
                    pc_d = next_pc_c;
                end
            end else if (redir_c) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redir_target_c;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BUSCA;
            pc_q          <= PC_RESET;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            contador_q    <= '0;
            erro_q        <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            contador_q    <= contador_d;
            erro_q        <= erro_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc               = pc_q;
    assign imem_req         = imem_req_c;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign instr_valid      = instr_valid_q;
    assign contador_instr   = contador_q;
    assign erro_alinhamento = erro_q;

endmodule

// File: tb/tb_unidade_busca_pc.sv
// Self-checking bench for unidade_busca_pc: directed scenarios plus randomized traffic
// compared against a transaction-level fetch model.
module tb_unidade_busca_pc;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance (PC_RESET = 0)
    logic        reset, branch_taken, jump, jr, stall, imem_ready;
    logic [31:0] branch_target, jump_target, jr_target, imem_data;
    logic [31:0] pc, pc_mais4, instr, instr_pc, contador_instr;
    logic        imem_req, instr_valid, erro_alinhamento;

    assign pc_mais4 = pc + 32'd4;

    unidade_busca_pc #(.PC_RESET(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_mais4(pc_mais4),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .stall(stall), .imem_req(imem_req), .imem_ready(imem_ready), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .contador_instr(contador_instr), .erro_alinhamento(erro_alinhamento)
    );

    // Second instance exercising the address wrap
    logic        reset2, stall2, imem_ready2, zero2;
    logic [31:0] zero32, imem_data2;
    logic [31:0] pc2, pc_mais4_2, instr2, instr_pc2, contador2;
    logic        imem_req2, instr_valid2, erro2;

    assign pc_mais4_2 = pc2 + 32'd4;

    unidade_busca_pc #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clock(clock), .reset(reset2), .pc(pc2), .pc_mais4(pc_mais4_2),
        .branch_taken(zero2), .branch_target(zero32),
        .jump(zero2), .jump_target(zero32), .jr(zero2), .jr_target(zero32),
        .stall(stall2), .imem_req(imem_req2), .imem_ready(imem_ready2), .imem_data(imem_data2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .contador_instr(contador2), .erro_alinhamento(erro2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the fetch unit architecturally holds after each cycle
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt, m_pt;
    logic        m_vld, m_err, m_halt, m_pv;

    task automatic step(input logic rst, input logic rdy, input logic stl,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic j_r, input logic [31:0] rt);
        logic        exp_req, have;
        logic [31:0] tgt, nxt, data;
        data          = $urandom();
        reset         = rst;
        imem_ready    = rdy;
        stall         = stl;
        branch_taken  = br;  branch_target = bt;
        jump          = jp;  jump_target   = jt;
        jr            = j_r; jr_target     = rt;
        imem_data     = data;
        #1;
        exp_req = !rst && !m_halt && !stl;
        chk("imem_req", 32'(imem_req), 32'(exp_req));

        if (rst) begin
            m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_vld = 0; m_cnt = 0;
            m_err = 0; m_halt = 0; m_pv = 0; m_pt = 0;
        end else begin
            m_vld = 1'b0;
            if (!m_halt) begin
                have = 1'b1;
                tgt  = 32'h0;
                if (j_r)     tgt = rt;
                else if (jp) tgt = jt;
                else if (br) tgt = bt;
                else         have = 1'b0;
                if (exp_req && rdy) begin
                    nxt     = have ? tgt : (m_pv ? m_pt : m_pc + 32'd4);
                    m_instr = data;
                    m_ipc   = m_pc;
                    m_vld   = 1'b1;
                    m_cnt   = m_cnt + 32'd1;
                    m_pv    = 1'b0;
                    if (nxt[1:0] != 2'b00) begin
                        m_halt = 1'b1;
                        m_err  = 1'b1;
                    end else begin
                        m_pc = nxt;
                    end
                end else if (have) begin
                    m_pv = 1'b1;
                    m_pt = tgt;
                end
            end
        end

        @(posedge clock);
        @(negedge clock);
        chk("pc", pc, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_vld));
        if (m_vld) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
        chk("contador_instr", contador_instr, m_cnt);
        chk("erro_alinhamento", 32'(erro_alinhamento), 32'(m_err));
    endtask

    task automatic fetch(input logic br, input logic [31:0] bt);
        step(1'b0, 1'b1, 1'b0, br, bt, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wrap_cycle(input logic rst, input logic rdy);
        reset2      = rst;
        imem_ready2 = rdy;
        imem_data2  = $urandom();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] r, bt, jt, rt;
        logic        br, jp, j_r, rdy, stl, rst;

        zero2 = 1'b0; zero32 = 32'h0; stall2 = 1'b0;
        reset2 = 1'b1; imem_ready2 = 1'b0; imem_data2 = 32'h0;
        m_pc = 0; m_instr = 0; m_ipc = 0; m_vld = 0; m_cnt = 0;
        m_err = 0; m_halt = 0; m_pv = 0; m_pt = 0;
        @(negedge clock);

        // Reset, then sequential fetch
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        chk("reset_pc", pc, 32'h0);
        fetch(1'b0, 0);
        fetch(1'b0, 0);
        chk("seq_pc8", pc, 32'h8);
        chk("seq_ipc4", instr_pc, 32'h4);

        // Branch at pc=8, then jr beats jump
        fetch(1'b1, 32'h40);
        chk("branch_pc", pc, 32'h40);
        chk("branch_ipc", instr_pc, 32'h8);
        chk("cnt3", contador_instr, 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h200, 1'b1, 32'h100);
        chk("jr_over_jump", pc, 32'h100);

        // Redirect captured while waiting
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h10, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h80, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        chk("wait_pc_hold", pc, 32'h10);
        fetch(1'b0, 0);
        chk("pending_pc", pc, 32'h80);

        // Stall with ready high
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        chk("stall_pc", pc, 32'h80);
        fetch(1'b0, 0);
        chk("resume_ipc", instr_pc, 32'h80);

        // Misaligned target halts fetch
        fetch(1'b1, 32'h42);
        chk("misalign_vld", 32'(instr_valid), 32'd1);
        chk("misalign_pc", pc, 32'h84);
        chk("misalign_flag", 32'(erro_alinhamento), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        chk("err_cleared", 32'(erro_alinhamento), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom(); bt = {r[31:2], 2'b00};
            r   = $urandom(); jt = {r[31:2], 2'b00};
            r   = $urandom(); rt = {r[31:2], 2'b00};
            if ($urandom_range(0, 15) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) jt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            br  = ($urandom_range(0, 7) == 0);
            jp  = ($urandom_range(0, 9) == 0);
            j_r = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 150) == 0) || (m_halt && $urandom_range(0, 5) == 0);
            step(rst, rdy, stl, br, bt, jp, jt, j_r, rt);
        end

        // Address wrap and reset abandoning a request
        wrap_cycle(1'b1, 1'b1);
        chk("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_reset_vld", 32'(instr_valid2), 32'd0);
        reset2 = 1'b0; imem_ready2 = 1'b1; #1;
        chk("wrap_req", 32'(imem_req2), 32'd1);
        wrap_cycle(1'b0, 1'b1);
        chk("wrap_pc0", pc2, 32'h0);
        chk("wrap_ipc", instr_pc2, 32'hFFFF_FFFC);
        chk("wrap_vld", 32'(instr_valid2), 32'd1);
        chk("wrap_noerr", 32'(erro2), 32'd0);
        wrap_cycle(1'b0, 1'b0);
        chk("wrap_wait_pc", pc2, 32'h0);
        chk("wrap_wait_vld", 32'(instr_valid2), 32'd0);
        reset2 = 1'b1; imem_ready2 = 1'b1; #1;
        chk("rst_req_low", 32'(imem_req2), 32'd0);
        wrap_cycle(1'b1, 1'b1);
        chk("rst_late_ready_vld", 32'(instr_valid2), 32'd0);
        chk("rst_late_ready_pc", pc2, 32'hFFFF_FFFC);
        chk("rst_late_ready_cnt", contador2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
